// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: control state encoding
// and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - br, bo is the borrow out of this bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  // Difference and borrow for a single bit position
  always_comb begin
    d  = a ^ b ^ br;
    bo = (~a & b) | (~(a ^ b) & br);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A - B - Bin one bit per clock, LSB first.
// Operands are captured into shift registers on the input handshake; each RUN
// cycle feeds the low bits through a single full_subtractor and shifts the
// resulting difference and borrow bits in from the top, so after WIDTH cycles
// every bit sits in its final position. WIDTH must be at least 2.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH:1]   Bout
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:1]   bout_reg;
  logic             bit_d;
  logic             bit_bo;
  logic             last_bit;

  assign last_bit = (idx == IDXW'(WIDTH - 1));

  full_subtractor u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .br (br),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, count bits in RUN, wait for consumer in DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture operands, then resolve one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      br       <= 1'b0;
      d_reg    <= '0;
      bout_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B;
            br       <= Bin;
            idx      <= '0;
            d_reg    <= '0;
            bout_reg <= '0;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          br       <= bit_bo;
          d_reg    <= {bit_d, d_reg[WIDTH-1:1]};
          bout_reg <= {bit_bo, bout_reg[WIDTH:2]};
          if (!last_bit) idx <= idx + IDXW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign D    = d_reg;
  assign Bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected results
// filled on each accepted operand set and drained when a result appears.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [3:0] d;
    logic [4:1] bout;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       Bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] D;
  logic [4:1] Bout;

  int checks = 0;
  int errors = 0;
  result_t sb[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Arithmetic reference: Bout[i] is set when the low i bits of A are below the low i bits of B plus Bin
  function automatic result_t modelSub(input logic [3:0] a, input logic [3:0] b, input logic bin);
    result_t r;
    logic [3:0] t;
    int mask;
    t = a - b - {3'b000, bin};
    r.d = t;
    r.bout = '0;
    for (int i = 1; i <= 4; i++) begin
      mask = (1 << i) - 1;
      r.bout[i] = ((int'(a) & mask) < ((int'(b) & mask) + int'(bin)));
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand set, wait for acceptance, push its expected result
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int n;
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    A = ~a;
    B = ~b;
    Bin = ~bin;
    sb.push_back(modelSub(a, b, bin));
  endtask

  // Wait for out_valid, then pop the scoreboard and compare
  task automatic collectResult(input string tag, input bit check_latency);
    int n;
    result_t exp;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) checkOutput({tag, "_timeout"}, 32'(out_valid), 32'd1);
    if (check_latency) checkOutput({tag, "_latency"}, 32'(n), 32'(WIDTH));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checkOutput({tag, "_D"}, 32'(D), 32'(exp.d));
      checkOutput({tag, "_Bout"}, 32'(Bout), 32'(exp.bout));
    end else begin
      checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ir_after"}, 32'(in_ready), 32'd1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, exhaustive sweep, stall and reset cases
  initial begin
    result_t exp;
    int cnt;
    logic [3:0] d_hold;
    logic [4:1] b_hold;

    rst_n = 1'b0;
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_D", 32'(D), 32'd0);
    checkOutput("rst_Bout", 32'(Bout), 32'd0);
    rst_n = 1'b1;
    step();

    applyStimulus(4'd5, 4'd3, 1'b0);
    checkOutput("run_in_ready", 32'(in_ready), 32'd0);
    collectResult("5m3", 1'b1);
    checkOutput("5m3_D_lit", 32'(D), 32'b0010);
    checkOutput("5m3_Bout_lit", 32'(Bout), 32'b0010);
    handshake("5m3");

    applyStimulus(4'd0, 4'd1, 1'b0);
    collectResult("0m1", 1'b1);
    checkOutput("0m1_D_lit", 32'(D), 32'b1111);
    checkOutput("0m1_Bout_lit", 32'(Bout), 32'b1111);
    handshake("0m1");

    applyStimulus(4'd0, 4'd0, 1'b1);
    collectResult("0m0b", 1'b1);
    checkOutput("0m0b_D_lit", 32'(D), 32'b1111);
    checkOutput("0m0b_Bout_lit", 32'(Bout), 32'b1111);
    handshake("0m0b");

    for (int bi = 0; bi < 2; bi++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bb = 0; bb < 16; bb++) begin
          applyStimulus(4'(ai), 4'(bb), 1'(bi));
          collectResult("sweep", 1'b0);
          checkOutput("sweep_bout4", 32'(Bout[4]), 32'(ai < bb + bi));
          out_ready = 1'b1;
          step();
          out_ready = 1'b0;
        end
      end
    end

    applyStimulus(4'd12, 4'd7, 1'b1);
    collectResult("stall", 1'b1);
    d_hold = D;
    b_hold = Bout;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      A = 4'(k + 1);
      B = 4'(k + 2);
      step();
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_D", 32'(D), 32'(d_hold));
      checkOutput("stall_Bout", 32'(Bout), 32'(b_hold));
    end
    in_valid = 1'b0;
    checkOutput("stall_D_value", 32'(D), 32'd4);
    handshake("stall");
    for (int k = 0; k < 8; k++) begin
      step();
      checkOutput("no_queue_out_valid", 32'(out_valid), 32'd0);
    end

    out_ready = 1'b1;
    applyStimulus(4'd3, 4'd9, 1'b0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) begin
        cnt++;
        exp = sb.pop_front();
        checkOutput("oneshot_D", 32'(D), 32'(exp.d));
        checkOutput("oneshot_Bout", 32'(Bout), 32'(exp.bout));
      end
    end
    checkOutput("oneshot_count", 32'(cnt), 32'd1);
    out_ready = 1'b0;

    applyStimulus(4'd15, 4'd2, 1'b0);
    step();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_back());
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_D", 32'(D), 32'd0);
    checkOutput("midrst_Bout", 32'(Bout), 32'd0);

    applyStimulus(4'd9, 4'd4, 1'b0);
    collectResult("9m4", 1'b1);
    checkOutput("9m4_D_lit", 32'(D), 32'd5);
    checkOutput("9m4_bout4", 32'(Bout[4]), 32'd0);
    handshake("9m4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and difference width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set A/B/Bin is valid.
REQ-005 Port: in_ready  output  1  block accepts a new operand set.
REQ-006 Port: A  input  WIDTH  minuend.
REQ-007 Port: B  input  WIDTH  subtrahend.
REQ-008 Port: Bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  D/Bout hold a completed result.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: D  output  WIDTH  difference, A - B - Bin modulo 2^WIDTH.
REQ-012 Port: Bout  output  [WIDTH:1]  per-bit borrow-out; Bout[i] is the borrow out of bit i-1, and Bout[WIDTH] is the final borrow.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0.
REQ-015 In IDLE, when in_valid & in_ready at a rising edge: capture A, B and Bin; clear bit index to 0; clear the D and Bout registers; go to RUN.
REQ-016 In RUN: in_ready=0, out_valid=0; A, B and Bin changes are ignored.
REQ-017 Each RUN edge SHALL resolve exactly one bit, LSB first, as follows:
- D[i] = a ^ b ^ br
- Bout[i+1] = (~a & b) | (~(a ^ b) & br)
- br is Bin for i=0, and Bout[i] for i>0.
REQ-018 After bit WIDTH-1 resolves, the FSM SHALL go to DONE; out_valid therefore rises exactly WIDTH edges after the accepting edge (4 for the default).
REQ-019 In DONE: out_valid=1, in_ready=0; D and Bout SHALL stay stable until out_valid & out_ready.
REQ-020 On out_valid & out_ready: go to IDLE; D and Bout SHALL hold their last values.
REQ-021 There is no overlap: in_ready rises no earlier than the cycle after the output handshake, so the minimum initiation interval is WIDTH+2 cycles.
REQ-022 When out_ready is held high in DONE: out_valid SHALL be high for exactly one cycle.
REQ-023 The bit index SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap inside RUN; DONE is entered on index == WIDTH-1.
REQ-024 in_valid while not in IDLE SHALL have no effect and SHALL not be queued.
REQ-025 Bout[WIDTH] = 1 exactly when A < B + Bin, evaluated as unsigned values.

Reset
REQ-026 When rst_n = 0 at a rising edge, regardless of state, the block SHALL apply: FSM=IDLE, index=0, D=0, Bout=0, out_valid=0, in_ready=1 on the following cycle.
REQ-027 Reset in RUN or DONE SHALL discard the in-flight operation, with no partial result presented.
REQ-028 Reset SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-029 A shared package serial_subtractor_pkg SHALL hold:
- the FSM state typedef (IDLE/RUN/DONE)
- the default WIDTH constant.
REQ-030 A single-bit combinational sub-module full_subtractor (inputs a, b, br; outputs d, bo) SHALL be instantiated once and reused each RUN cycle.
REQ-031 Shift or capture registers SHALL stay in the top module; there SHALL be no other sub-modules.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- A=4'd5, B=4'd3, Bin=0 -> after 4 edges out_valid=1, D=4'b0010, Bout=4'b0010.
- A=0, B=1, Bin=0 -> D=4'b1111, Bout=4'b1111.
- A=0, B=0, Bin=1 -> D=4'b1111, Bout=4'b1111.
- Exhaustive sweep of all 512 {Bin,A,B} combinations -> D == (A-B-Bin) mod 16 and Bout[4] == (A < B+Bin) every time.
- out_ready held low 3 cycles in DONE -> D, Bout and out_valid stable; in_ready stays 0; in_valid pulses ignored.
- rst_n=0 on the 2nd RUN cycle -> next cycle IDLE with in_ready=1, out_valid=0, D=0, Bout=0; a fresh 4'd9 - 4'd4 then yields D=4'd5, Bout[4]=0.
